wire_ops_arbiter: RTL



---
 rtl/wire_ops_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/wire_ops_arbiter.sv
// Round-robin arbiter sharing one registered wire-ops ALU (AND/XOR) between NUM_REQ requesters.
// Optional per-requester saturating grant counters are enabled by defining WIRE_OPS_ARB_STATS_EN.
module wire_ops_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = 2
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_sel,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_y,
    output logic [ID_W-1:0]          rsp_id
`ifdef WIRE_OPS_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]    stat_grants
`endif
);

    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic [WIDTH-1:0] a_arr [NUM_REQ];
    logic [WIDTH-1:0] b_arr [NUM_REQ];
    logic [ID_W-1:0]  winner;
    logic             found;
    logic             can_accept;
    logic             grant_en;
    logic [WIDTH-1:0] alu_y;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
        assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
    end

    // Scan from rr_ptr upward, wrapping modulo NUM_REQ (which need not be a power of two).
    always_comb begin
        logic [ID_W:0] idx_w;
        winner = '0;
        found  = 1'b0;
        idx_w  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_w = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (idx_w >= (ID_W+1)'(NUM_REQ)) begin
                idx_w = idx_w - (ID_W+1)'(NUM_REQ);
            end
            if (!found && req_valid[idx_w[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = idx_w[ID_W-1:0];
            end
        end
    end

    assign can_accept = !rsp_valid_q || rsp_ready;
    // Gating with sys_rst keeps every req_ready low while reset is held.
    assign grant_en   = found && can_accept && sys_rst;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign req_ready[gi] = grant_en && (winner == ID_W'(gi)) && req_valid[gi];
    end

    assign alu_y = req_sel[winner] ? (a_arr[winner] & b_arr[winner])
                                   : (a_arr[winner] ^ b_arr[winner]);

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_y_d     = rsp_y_q;
        rsp_id_d    = rsp_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (grant_en) begin
            rsp_valid_d = 1'b1;
            rsp_y_d     = alu_y;
            rsp_id_d    = winner;
            rr_ptr_d    = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_id_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_id_q    <= rsp_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_id    = rsp_id_q;

`ifdef WIRE_OPS_ARB_STATS_EN
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
        logic [15:0] grants_q;
        always_ff @(posedge sys_clk or negedge sys_rst) begin
            if (!sys_rst) begin
                grants_q <= '0;
            end else if (req_ready[gi] && (grants_q != 16'hFFFF)) begin
                grants_q <= grants_q + 16'd1;
            end
        end
        assign stat_grants[gi*16 +: 16] = grants_q;
    end
`endif

endmodule
